// File: rtl/instr_sequencer.sv
// instr_sequencer -- fetch/decode/execute controller for the 16-bit CPU.
//
// Fetches one instruction word per FETCH over a req/ack read port, holds it
// in ir, drives the ALU opcode/operand-select fields straight from ir and
// strobes the register-file write in EXEC of ALU-class instructions.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_rd/mem_addr       read request (FETCH only) / address (= pc)
//   mem_ack/mem_rdata     read acknowledge and instruction word
//   instr_bit_15          ir[15]      (ALU opcode msb)
//   instr_bit_12_11       ir[12:11]   (ALU opcode lsbs)
//   rs_sel / rm_sel       ir[10:8] / ir[7:5]
//   N                     immediate {8'h00, ir[7:0]}
//   reg_we                register-file write strobe
//   pc, halted            program counter, HLT executed
//   retired               retired-instruction count (INSTR_SEQUENCER_RETIRED_EN)
//
// Optional feature macro: INSTR_SEQUENCER_RETIRED_EN adds the retired port.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_bit_15,
  output logic [1:0]  instr_bit_12_11,
  output logic [2:0]  rs_sel,
  output logic [2:0]  rm_sel,
  output logic [15:0] N,
  output logic        reg_we,
  output logic [15:0] pc,
  output logic        halted
`ifdef INSTR_SEQUENCER_RETIRED_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        mem_rd_q, mem_rd_d;
  logic        reg_we_q, reg_we_d;
  logic        halted_q, halted_d;
`ifdef INSTR_SEQUENCER_RETIRED_EN
  logic [15:0] ret_q, ret_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef INSTR_SEQUENCER_RETIRED_EN
    ret_d   = ret_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[14:13] == 2'b11) begin
          state_d = S_HALT;
`ifdef INSTR_SEQUENCER_RETIRED_EN
          ret_d   = ret_q + 16'd1;   // HLT retires on entering HALT
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // JMP target replaces the increment taken in FETCH
        if (ir_q[14:13] == 2'b10) pc_d = {8'h00, ir_q[7:0]};
        state_d = S_FETCH;
`ifdef INSTR_SEQUENCER_RETIRED_EN
        ret_d   = ret_q + 16'd1;
`endif
      end
      default: state_d = S_HALT;
    endcase
    // Outputs are registered from the next-state decode
    mem_rd_d = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT);
    reg_we_d = (state_d == S_EXEC) && (ir_d[14:13] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      mem_rd_q <= 1'b1;
      reg_we_q <= 1'b0;
      halted_q <= 1'b0;
`ifdef INSTR_SEQUENCER_RETIRED_EN
      ret_q    <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mem_rd_q <= mem_rd_d;
      reg_we_q <= reg_we_d;
      halted_q <= halted_d;
`ifdef INSTR_SEQUENCER_RETIRED_EN
      ret_q    <= ret_d;
`endif
    end
  end

  assign mem_rd          = mem_rd_q;
  assign mem_addr        = pc_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  // A reset arriving in EXEC wins over the pending write at that edge
  assign reg_we          = reg_we_q & ~reset;
  assign instr_bit_15    = ir_q[15];
  assign instr_bit_12_11 = ir_q[12:11];
  assign rs_sel          = ir_q[10:8];
  assign rm_sel          = ir_q[7:5];
  assign N               = {8'h00, ir_q[7:0]};
`ifdef INSTR_SEQUENCER_RETIRED_EN
  assign retired         = ret_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rd, reg_we, halted, instr_bit_15;
  logic [15:0] mem_addr, N, pc;
  logic [1:0]  instr_bit_12_11;
  logic [2:0]  rs_sel, rm_sel;
`ifdef INSTR_SEQUENCER_RETIRED_EN
  logic [15:0] retired, w_retired;
`endif

  // second instance starting at FFFF to exercise pc wrap
  logic        w_ack = 1'b0;
  logic [15:0] w_rdata = 16'h0000;
  logic        w_rd, w_we, w_halted, w_b15;
  logic [15:0] w_addr, w_n, w_pc;
  logic [1:0]  w_b1211;
  logic [2:0]  w_rs, w_rm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_bit_15(instr_bit_15),
    .instr_bit_12_11(instr_bit_12_11), .rs_sel(rs_sel), .rm_sel(rm_sel),
    .N(N), .reg_we(reg_we), .pc(pc), .halted(halted)
`ifdef INSTR_SEQUENCER_RETIRED_EN
    , .retired(retired)
`endif
  );

  instr_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .reset(reset), .mem_rd(w_rd), .mem_addr(w_addr),
    .mem_ack(w_ack), .mem_rdata(w_rdata), .instr_bit_15(w_b15),
    .instr_bit_12_11(w_b1211), .rs_sel(w_rs), .rm_sel(w_rm),
    .N(w_n), .reg_we(w_we), .pc(w_pc), .halted(w_halted)
`ifdef INSTR_SEQUENCER_RETIRED_EN
    , .retired(w_retired)
`endif
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_we;
    logic        e_halt;
    logic [15:0] e_ir;
    logic [15:0] e_ret;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t row(logic rst, logic ack, logic [15:0] rdata,
                               logic e_rd, logic [15:0] e_addr, logic e_we,
                               logic e_halt, logic [15:0] e_ir, logic [15:0] e_ret);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.e_rd = e_rd; v.e_addr = e_addr;
    v.e_we = e_we; v.e_halt = e_halt; v.e_ir = e_ir; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive one cycle's inputs away from the active edge, let outputs settle
  task automatic cyc(input logic rst, input logic ack, input logic [15:0] rd);
    @(negedge clk);
    reset = rst; mem_ack = ack; mem_rdata = rd;
    #1;
  endtask

  initial begin
    //         rst ack rdata     rd addr      we halt ir        ret
    tbl[0]  = row(1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'd0);
    tbl[1]  = row(0, 1, 16'h0103, 1, 16'h0000, 0, 0, 16'h0000, 16'd0);
    tbl[2]  = row(0, 0, 16'h0000, 0, 16'h0001, 0, 0, 16'h0103, 16'd0);
    tbl[3]  = row(0, 0, 16'h0000, 0, 16'h0001, 1, 0, 16'h0103, 16'd0);
    tbl[4]  = row(0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0103, 16'd1);
    tbl[5]  = row(0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0103, 16'd1);
    tbl[6]  = row(0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0103, 16'd1);
    tbl[7]  = row(0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0103, 16'd1);
    tbl[8]  = row(0, 1, 16'h9AE5, 1, 16'h0001, 0, 0, 16'h0103, 16'd1);
    tbl[9]  = row(0, 1, 16'hFFFF, 0, 16'h0002, 0, 0, 16'h9AE5, 16'd1);
    tbl[10] = row(0, 1, 16'hFFFF, 0, 16'h0002, 1, 0, 16'h9AE5, 16'd1);
    tbl[11] = row(0, 1, 16'h4042, 1, 16'h0002, 0, 0, 16'h9AE5, 16'd2);
    tbl[12] = row(0, 0, 16'h0000, 0, 16'h0003, 0, 0, 16'h4042, 16'd2);
    tbl[13] = row(0, 0, 16'h0000, 0, 16'h0003, 0, 0, 16'h4042, 16'd2);
    tbl[14] = row(0, 1, 16'h2000, 1, 16'h0042, 0, 0, 16'h4042, 16'd3);
    tbl[15] = row(0, 0, 16'h0000, 0, 16'h0043, 0, 0, 16'h2000, 16'd3);
    tbl[16] = row(0, 0, 16'h0000, 0, 16'h0043, 0, 0, 16'h2000, 16'd3);
    tbl[17] = row(0, 1, 16'h6000, 1, 16'h0043, 0, 0, 16'h2000, 16'd4);
    tbl[18] = row(0, 0, 16'h0000, 0, 16'h0044, 0, 0, 16'h6000, 16'd4);
    tbl[19] = row(0, 1, 16'h0103, 0, 16'h0044, 0, 1, 16'h6000, 16'd5);
    tbl[20] = row(0, 1, 16'h0103, 0, 16'h0044, 0, 1, 16'h6000, 16'd5);

    for (int i = 0; i < 21; i++) begin
      logic [15:0] ir;
      cyc(tbl[i].rst, tbl[i].ack, tbl[i].rdata);
      ir = tbl[i].e_ir;
      chk1 ($sformatf("v%0d mem_rd", i),   mem_rd,   tbl[i].e_rd);
      chk16($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      chk16($sformatf("v%0d pc", i),       pc,       tbl[i].e_addr);
      chk1 ($sformatf("v%0d reg_we", i),   reg_we,   tbl[i].e_we);
      chk1 ($sformatf("v%0d halted", i),   halted,   tbl[i].e_halt);
      chk1 ($sformatf("v%0d b15", i),      instr_bit_15, ir[15]);
      chk16($sformatf("v%0d b12_11", i),   {14'd0, instr_bit_12_11}, {14'd0, ir[12:11]});
      chk16($sformatf("v%0d rs_sel", i),   {13'd0, rs_sel}, {13'd0, ir[10:8]});
      chk16($sformatf("v%0d rm_sel", i),   {13'd0, rm_sel}, {13'd0, ir[7:5]});
      chk16($sformatf("v%0d N", i),        N, {8'h00, ir[7:0]});
`ifdef INSTR_SEQUENCER_RETIRED_EN
      chk16($sformatf("v%0d retired", i),  retired, tbl[i].e_ret);
`endif
    end

    // HALT is absorbing with mem_ack pulsing
    for (int i = 0; i < 20; i++) begin
      cyc(0, i[0], 16'h0103);
      chk1($sformatf("halt%0d mem_rd", i), mem_rd, 1'b0);
      chk1($sformatf("halt%0d halted", i), halted, 1'b1);
      chk16($sformatf("halt%0d pc", i), pc, 16'h0044);
    end

    // two ALU ops then HLT, mem_ack held high throughout
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'h0103);
    chk16("seqB c0 mem_addr", mem_addr, 16'h0000);
    chk1 ("seqB c0 mem_rd", mem_rd, 1'b1);
    cyc(0, 1, 16'h0103);
    chk16("seqB c1 rs_sel", {13'd0, rs_sel}, 16'd1);
    chk16("seqB c1 N", N, 16'h0003);
    cyc(0, 1, 16'h0103);
    chk1 ("seqB c2 reg_we", reg_we, 1'b1);
    chk1 ("seqB c2 b15", instr_bit_15, 1'b0);
    chk16("seqB c2 b12_11", {14'd0, instr_bit_12_11}, 16'd0);
    chk16("seqB c2 rs_sel", {13'd0, rs_sel}, 16'd1);
    chk16("seqB c2 N", N, 16'h0003);
    cyc(0, 1, 16'h0103);
    chk16("seqB c3 mem_addr", mem_addr, 16'h0001);
    cyc(0, 1, 16'h0103);
    cyc(0, 1, 16'h0103);
    cyc(0, 1, 16'h6000);
    chk16("seqB c6 mem_addr", mem_addr, 16'h0002);
    cyc(0, 1, 16'h6000);
    chk1 ("seqB c7 halted", halted, 1'b0);
    chk1 ("seqB c7 reg_we", reg_we, 1'b0);
    cyc(0, 1, 16'h6000);
    chk1 ("seqB c8 halted", halted, 1'b1);
    chk1 ("seqB c8 mem_rd", mem_rd, 1'b0);
`ifdef INSTR_SEQUENCER_RETIRED_EN
    chk16("seqB retired", retired, 16'd3);
`endif

    // reset during EXEC; mem_ack during DECODE and during reset ignored
    cyc(1, 0, 16'h0000);
    cyc(0, 1, 16'h9AE5);
    cyc(0, 1, 16'hFFFF);
    chk16("seqD decode rs_sel", {13'd0, rs_sel}, 16'd2);
    chk16("seqD decode N", N, 16'h00E5);
    cyc(1, 1, 16'h0103);
    chk1 ("seqD exec+reset reg_we", reg_we, 1'b0);
    chk16("seqD exec ir kept N", N, 16'h00E5);
    chk16("seqD exec ir kept rm", {13'd0, rm_sel}, 16'd7);
    cyc(1, 1, 16'h0103);
    chk16("seqD after reset pc", pc, 16'h0000);
    chk1 ("seqD after reset mem_rd", mem_rd, 1'b1);
    chk16("seqD after reset N", N, 16'h0000);
    cyc(0, 0, 16'h0000);
    chk1 ("seqD ack in reset dropped mem_rd", mem_rd, 1'b1);
    chk16("seqD ack in reset dropped pc", pc, 16'h0000);
    chk16("seqD ack in reset dropped rs", {13'd0, rs_sel}, 16'd0);

    // pc wrap: NOP fetched at FFFF
    cyc(1, 0, 16'h0000);
    @(negedge clk); reset = 1'b0; w_ack = 1'b1; w_rdata = 16'h2000; #1;
    chk16("wrap fetch addr", w_addr, 16'hFFFF);
    chk1 ("wrap fetch rd", w_rd, 1'b1);
    @(negedge clk); w_ack = 1'b0; #1;
    chk16("wrap pc after fetch", w_pc, 16'h0000);
    @(negedge clk); #1;
    chk1 ("wrap nop no reg_we", w_we, 1'b0);
    @(negedge clk); #1;
    chk16("wrap next fetch addr", w_addr, 16'h0000);
    chk1 ("wrap next fetch rd", w_rd, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
